ram_port_arbiter: RTL and testbench

- Shares the simple dual-port block RAM between NUM_REQ requesters, such as the instruction fetch of several stage1 instances, a loader and a debug port.
- Write port A and read port B are arbitrated independently, each with its own round-robin pointer.
- A same-address read/write collision within one cycle is resolved in favour of the write.
- The block sits between the requesters and simple_dual_two_clocks; the top level ties the RAM's clkb to clka.

---
 rtl/ram_port_arbiter_pkg.sv | 18 +
 rtl/ram_port_arbiter_rr_pick.sv | 36 +++
 rtl/ram_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the block-RAM port arbiter: default geometry,
// port encoding for debug display and the pointer-width helper.
package ram_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic {
    PORT_WRITE = 1'b0,
    PORT_READ  = 1'b1
  } port_e;

  // A single requester still needs a 1-bit pointer/index.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first candidate at or above ptr wins,
// otherwise the first candidate below ptr.
module rr_pick
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = ptr_width(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && cand[k] && (k >= int'(ptr))) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = PW'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!any && cand[k] && (k < int'(ptr))) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = PW'(k);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates NUM_REQ requesters onto a simple dual-port block RAM: write port A
// and read port B each have an independent round-robin pointer.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic                      clka,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      ena,
  output logic                      wea,
  output logic [ADDR_W-1:0]         addra,
  output logic [DATA_W-1:0]         dia,
  output logic                      enb,
  output logic [ADDR_W-1:0]         addrb,
  input  logic [DATA_W-1:0]         dob
);

  localparam int unsigned PW = ptr_width(NUM_REQ);

  logic [NUM_REQ-1:0] wr_cand, rd_cand, wr_gnt, rd_gnt;
  logic [PW-1:0]      wr_idx, rd_idx;
  logic               wr_any, rd_any, collide, rd_ok;
  logic [ADDR_W-1:0]  wr_addr, rd_addr;
  logic [DATA_W-1:0]  wr_data;

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               ena_q, enb_q;
  logic [ADDR_W-1:0]  addra_q, addrb_q;
  logic [DATA_W-1:0]  dia_q;
  logic [PW-1:0]      rd_idx_q;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

  assign wr_cand = req_valid & req_we;
  assign rd_cand = req_valid & ~req_we;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_wr_pick (
    .cand (wr_cand),
    .ptr  (wr_ptr_q),
    .gnt  (wr_gnt),
    .idx  (wr_idx),
    .any  (wr_any)
  );

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rd_pick (
    .cand (rd_cand),
    .ptr  (rd_ptr_q),
    .gnt  (rd_gnt),
    .idx  (rd_idx),
    .any  (rd_any)
  );

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (PW'(k) == wr_idx) begin
        wr_addr = req_addr[k*ADDR_W +: ADDR_W];
        wr_data = req_wdata[k*DATA_W +: DATA_W];
      end
      if (PW'(k) == rd_idx) begin
        rd_addr = req_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // Same-address collision: the write wins, the read retries next cycle.
  assign collide   = wr_any & rd_any & (wr_addr == rd_addr);
  assign rd_ok     = rd_any & ~collide;
  assign req_ready = rst ? '0 : (wr_gnt | (rd_ok ? rd_gnt : '0));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_any) begin
      wr_ptr_d = (wr_idx == PW'(NUM_REQ - 1)) ? '0 : wr_idx + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = (rd_idx == PW'(NUM_REQ - 1)) ? '0 : rd_idx + 1'b1;
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    if (enb_q) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (PW'(k) == rd_idx_q) begin
          rsp_valid_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ena_q       <= 1'b0;
      enb_q       <= 1'b0;
      addra_q     <= '0;
      addrb_q     <= '0;
      dia_q       <= '0;
      rd_idx_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ena_q       <= wr_any;
      enb_q       <= rd_ok;
      rsp_valid_q <= rsp_valid_d;
      if (wr_any) begin
        addra_q <= wr_addr;
        dia_q   <= wr_data;
      end
      if (rd_ok) begin
        addrb_q  <= rd_addr;
        rd_idx_q <= rd_idx;
      end
    end
  end

  assign ena       = ena_q;
  assign wea       = ena_q;
  assign addra     = addra_q;
  assign dia       = dia_q;
  assign enb       = enb_q;
  assign addrb     = addrb_q;
  assign rsp_valid = rsp_valid_q;
  // The RAM registers dob; it is valid in the same cycle as rsp_valid.
  assign rsp_data  = dob;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural simple dual-port RAM
// attached to ports A and B.
module tb_ram_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 16;

  logic              clka = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_we, req_ready, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rsp_data, dia, dob;
  logic [AW-1:0]     addra, addrb;
  logic              ena, wea, enb;

  logic [DW-1:0]     mem [0:(1<<AW)-1];

  int nvec = 0;
  int nerr = 0;

  always #5 clka = ~clka;

  always @(posedge clka) begin
    if (ena && wea) mem[addra] <= dia;
    if (enb) dob <= mem[addrb];
  end

  ram_port_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clka      (clka),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ena       (ena),
    .wea       (wea),
    .addra     (addra),
    .dia       (dia),
    .enb       (enb),
    .addrb     (addrb),
    .dob       (dob)
  );

  task automatic step;
    @(posedge clka);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_reqs();
    req_valid = '1;
    @(posedge clka);
    @(negedge clka);
    nvec++;
    if ({ena, wea, enb, addra, addrb, dia} !== '0) begin
      nerr++;
      $display("FAIL reset_ram_ports got %b%b%b %h %h %h want all zero", ena, wea, enb, addra,
               addrb, dia);
    end
    nvec++;
    if ({rsp_valid, req_ready} !== 8'h00) begin
      nerr++;
      $display("FAIL reset_valid_ready got rsp=%b rdy=%b want 0000/0000", rsp_valid, req_ready);
    end
    step();
    clear_reqs();
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    set_req(2, 1'b1, 1'b0, 10'h005, 16'h0);
    @(negedge clka);
    nvec++;
    if (req_ready !== 4'b0100) begin
      nerr++;
      $display("FAIL single_ready got %b want 0100", req_ready);
    end
    step();
    clear_reqs();
    @(negedge clka);
    nvec++;
    if ({enb, addrb, rsp_valid} !== {1'b1, 10'h005, 4'b0000}) begin
      nerr++;
      $display("FAIL single_cmd got enb=%b addrb=%h rsp=%b want 1/005/0000", enb, addrb,
               rsp_valid);
    end
    step();
    @(negedge clka);
    nvec++;
    if ({rsp_valid, rsp_data} !== {4'b0100, 16'h0A0B}) begin
      nerr++;
      $display("FAIL single_rsp got %b/%h want 0100/0a0b", rsp_valid, rsp_data);
    end
    step();
  endtask

  task automatic test_reset_mid_read;
    set_req(1, 1'b1, 1'b0, 10'h007, 16'h0);
    @(negedge clka);
    nvec++;
    if (req_ready !== 4'b0010) begin
      nerr++;
      $display("FAIL midrst_grant got %b want 0010", req_ready);
    end
    step();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 10'(10'h100 + i), 16'h0);
    @(negedge clka);
    nvec++;
    if ({enb, rsp_valid, req_ready} !== 9'h000) begin
      nerr++;
      $display("FAIL midrst_hold got enb=%b rsp=%b rdy=%b want 0/0000/0000", enb, rsp_valid,
               req_ready);
    end
    step();
    @(negedge clka);
    nvec++;
    if (rsp_valid !== 4'b0000) begin
      nerr++;
      $display("FAIL midrst_no_rsp got %b want 0000", rsp_valid);
    end
    step();
    rst = 1'b0;
    @(negedge clka);
    nvec++;
    if ({req_ready, rsp_valid} !== {4'b0001, 4'b0000}) begin
      nerr++;
      $display("FAIL midrst_first got rdy=%b rsp=%b want 0001/0000", req_ready, rsp_valid);
    end
    step();
    clear_reqs();
    @(negedge clka);
    nvec++;
    if ({enb, addrb} !== {1'b1, 10'h100}) begin
      nerr++;
      $display("FAIL midrst_cmd got %b/%h want 1/100", enb, addrb);
    end
    step();
    @(negedge clka);
    nvec++;
    if (rsp_valid !== 4'b0001) begin
      nerr++;
      $display("FAIL midrst_rsp got %b want 0001", rsp_valid);
    end
    step();
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy, exp_rsp;
    rst = 1'b1;
    clear_reqs();
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) req_valid = '1;
      else clear_reqs();
      exp_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      exp_rsp = (c >= 2) ? 4'(1 << ((c - 2) % 4)) : 4'b0000;
      @(negedge clka);
      nvec++;
      if ({req_ready, rsp_valid} !== {exp_rdy, exp_rsp}) begin
        nerr++;
        $display("FAIL rr_cycle%0d got rdy=%b rsp=%b want %b/%b", c, req_ready, rsp_valid,
                 exp_rdy, exp_rsp);
      end
      step();
    end
  endtask

  task automatic test_parallel;
    set_req(0, 1'b1, 1'b1, 10'h010, 16'h1234);
    set_req(1, 1'b1, 1'b0, 10'h020, 16'h0);
    @(negedge clka);
    nvec++;
    if (req_ready !== 4'b0011) begin
      nerr++;
      $display("FAIL par_ready got %b want 0011", req_ready);
    end
    step();
    clear_reqs();
    @(negedge clka);
    nvec++;
    if ({ena, wea, addra, dia} !== {1'b1, 1'b1, 10'h010, 16'h1234}) begin
      nerr++;
      $display("FAIL par_write got %b%b %h %h want 11 010 1234", ena, wea, addra, dia);
    end
    nvec++;
    if ({enb, addrb} !== {1'b1, 10'h020}) begin
      nerr++;
      $display("FAIL par_read got %b/%h want 1/020", enb, addrb);
    end
    step();
    @(negedge clka);
    nvec++;
    if ({ena, rsp_valid, rsp_data} !== {1'b0, 4'b0010, 16'h2222}) begin
      nerr++;
      $display("FAIL par_rsp got ena=%b %b/%h want 0 0010/2222", ena, rsp_valid, rsp_data);
    end
    step();
  endtask

  task automatic test_collision;
    set_req(0, 1'b1, 1'b1, 10'h030, 16'hBEEF);
    set_req(3, 1'b1, 1'b0, 10'h030, 16'h0);
    @(negedge clka);
    nvec++;
    if (req_ready !== 4'b0001) begin
      nerr++;
      $display("FAIL coll_ready_t got %b want 0001", req_ready);
    end
    step();
    set_req(0, 1'b0, 1'b0, 10'h000, 16'h0);
    @(negedge clka);
    nvec++;
    if (req_ready !== 4'b1000) begin
      nerr++;
      $display("FAIL coll_ready_t1 got %b want 1000", req_ready);
    end
    nvec++;
    if ({ena, addra, dia, enb} !== {1'b1, 10'h030, 16'hBEEF, 1'b0}) begin
      nerr++;
      $display("FAIL coll_write got ena=%b %h %h enb=%b want 1 030 beef 0", ena, addra, dia, enb);
    end
    step();
    clear_reqs();
    @(negedge clka);
    nvec++;
    if ({enb, addrb} !== {1'b1, 10'h030}) begin
      nerr++;
      $display("FAIL coll_cmd got %b/%h want 1/030", enb, addrb);
    end
    step();
    @(negedge clka);
    nvec++;
    if ({rsp_valid, rsp_data} !== {4'b1000, 16'hBEEF}) begin
      nerr++;
      $display("FAIL coll_rsp got %b/%h want 1000/beef", rsp_valid, rsp_data);
    end
    step();
  endtask

  task automatic test_back_to_back;
    set_req(1, 1'b1, 1'b1, 10'h040, 16'h5555);
    @(negedge clka);
    nvec++;
    if (req_ready !== 4'b0010) begin
      nerr++;
      $display("FAIL b2b_wr_ready got %b want 0010", req_ready);
    end
    step();
    set_req(1, 1'b1, 1'b0, 10'h040, 16'h0);
    @(negedge clka);
    nvec++;
    if ({req_ready, ena, addra, dia} !== {4'b0010, 1'b1, 10'h040, 16'h5555}) begin
      nerr++;
      $display("FAIL b2b_rd_ready got rdy=%b ena=%b %h %h want 0010 1 040 5555", req_ready, ena,
               addra, dia);
    end
    step();
    clear_reqs();
    @(negedge clka);
    nvec++;
    if ({enb, addrb, ena} !== {1'b1, 10'h040, 1'b0}) begin
      nerr++;
      $display("FAIL b2b_cmd got enb=%b %h ena=%b want 1 040 0", enb, addrb, ena);
    end
    step();
    @(negedge clka);
    nvec++;
    if ({rsp_valid, rsp_data} !== {4'b0010, 16'h5555}) begin
      nerr++;
      $display("FAIL b2b_rsp got %b/%h want 0010/5555", rsp_valid, rsp_data);
    end
    step();
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
    mem[10'h005] = 16'h0A0B;
    mem[10'h020] = 16'h2222;
    dob = '0;
    test_reset();
    test_single_read();
    test_reset_mid_read();
    test_round_robin();
    test_parallel();
    test_collision();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
